// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M multiply/divide unit for the execute stage.
// Runs MUL/MULH/MULHSU/MULHU as an iterative shift-add multiplier and
// DIV/DIVU/REM/REMU as a restoring divider. Each takes DATA_WIDTH iterations
// plus one operand-preparation cycle and one sign-fix cycle.
//
// Ports:
//   clk     - system clock, rising edge
//   rst     - synchronous active-high reset, highest priority
//   start   - request; sampled only in IDLE or DONE
//   op      - funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   op_a    - rs1 value, latched with start
//   op_b    - rs2 value, latched with start
//   flush   - abort the in-flight operation, return to IDLE
//   busy    - high in PREP/CALC/FIX; stalls the pipeline
//   done    - one-cycle pulse when result is valid
//   result  - final value, held until the next completed operation
module muldiv_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t          state_r;
  logic [2:0]      op_r;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic [W-1:0]    opnd_r;     // multiplicand or divisor magnitude
  logic [2*W-1:0]  acc_r;      // product / {remainder, quotient}
  logic [CW-1:0]   cnt_r;
  logic            neg_r;      // product / quotient sign
  logic            rem_neg_r;  // remainder sign follows the dividend

  logic            sign_a_s;
  logic            sign_b_s;
  logic [W-1:0]    mag_a_s;
  logic [W-1:0]    mag_b_s;
  logic [W:0]      mul_sum_s;
  logic [2*W-1:0]  mul_next_s;
  logic [W:0]      rem_sh_s;
  logic [W:0]      diff_s;
  logic [2*W-1:0]  div_next_s;
  logic [2*W-1:0]  prod_s;
  logic [W-1:0]    quo_s;
  logic [W-1:0]    rem_s;
  logic            div_zero_s;
  logic            ovf_s;
  logic [W-1:0]    fix_s;

  // Magnitude of a possibly negative value; the W+1-bit intermediate keeps
  // the most negative input representable (its magnitude is 2^(W-1)).
  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic neg);
    logic [W:0] t;
    if (neg) begin
      t = {1'b1, ~v} + {{W{1'b0}}, 1'b1};
    end else begin
      t = {1'b0, v};
    end
    return t[W-1:0];
  endfunction

  // Operand signs/magnitudes, one iteration of each datapath, and FIX selection.
  always_comb begin
    sign_a_s = a_r[W-1] & ((op_r == OP_MULH) | (op_r == OP_MULHSU) |
                           (op_r == OP_DIV)  | (op_r == OP_REM));
    sign_b_s = b_r[W-1] & ((op_r == OP_MULH) | (op_r == OP_DIV) | (op_r == OP_REM));
    mag_a_s  = magnitude(a_r, sign_a_s);
    mag_b_s  = magnitude(b_r, sign_b_s);

    // Shift-add: the carry out of the high-half add becomes the new MSB.
    mul_sum_s  = {1'b0, acc_r[2*W-1:W]} + (acc_r[0] ? {1'b0, opnd_r} : {(W+1){1'b0}});
    mul_next_s = {mul_sum_s, acc_r[W-1:1]};

    // Restoring divide: bit W of the difference is the borrow.
    rem_sh_s = acc_r[2*W-1:W-1];
    diff_s   = rem_sh_s - {1'b0, opnd_r};
    if (diff_s[W]) begin
      div_next_s = {rem_sh_s[W-1:0], acc_r[W-2:0], 1'b0};
    end else begin
      div_next_s = {diff_s[W-1:0], acc_r[W-2:0], 1'b1};
    end

    prod_s = neg_r ? (~acc_r + {{(2*W-1){1'b0}}, 1'b1}) : acc_r;
    quo_s  = neg_r ? (~acc_r[W-1:0] + {{(W-1){1'b0}}, 1'b1}) : acc_r[W-1:0];
    rem_s  = rem_neg_r ? (~acc_r[2*W-1:W] + {{(W-1){1'b0}}, 1'b1}) : acc_r[2*W-1:W];

    div_zero_s = (b_r == {W{1'b0}});
    ovf_s      = (a_r == {1'b1, {(W-1){1'b0}}}) && (b_r == {W{1'b1}});

    case (op_r)
      OP_MUL:    fix_s = prod_s[W-1:0];
      OP_MULH:   fix_s = prod_s[2*W-1:W];
      OP_MULHSU: fix_s = prod_s[2*W-1:W];
      OP_MULHU:  fix_s = prod_s[2*W-1:W];
      OP_DIV: begin
        if (div_zero_s) begin
          fix_s = {W{1'b1}};
        end else if (ovf_s) begin
          fix_s = {1'b1, {(W-1){1'b0}}};
        end else begin
          fix_s = quo_s;
        end
      end
      OP_DIVU:   fix_s = div_zero_s ? {W{1'b1}} : quo_s;
      OP_REM: begin
        if (div_zero_s) begin
          fix_s = a_r;
        end else if (ovf_s) begin
          fix_s = {W{1'b0}};
        end else begin
          fix_s = rem_s;
        end
      end
      OP_REMU:   fix_s = div_zero_s ? a_r : rem_s;
      default:   fix_s = {W{1'b0}};
    endcase
  end

  // Sequencer FSM with registered busy/done/result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      op_r      <= 3'b000;
      a_r       <= {W{1'b0}};
      b_r       <= {W{1'b0}};
      opnd_r    <= {W{1'b0}};
      acc_r     <= {(2*W){1'b0}};
      cnt_r     <= {CW{1'b0}};
      neg_r     <= 1'b0;
      rem_neg_r <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= {W{1'b0}};
    end else if (flush) begin
      state_r <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            op_r    <= op;
            a_r     <= op_a;
            b_r     <= op_b;
            busy    <= 1'b1;
            state_r <= S_PREP;
          end else begin
            busy    <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        S_PREP: begin
          neg_r     <= sign_a_s ^ sign_b_s;
          rem_neg_r <= sign_a_s;
          cnt_r     <= {CW{1'b0}};
          if (op_r[2]) begin
            opnd_r <= mag_b_s;
            acc_r  <= {{W{1'b0}}, mag_a_s};
          end else begin
            opnd_r <= mag_a_s;
            acc_r  <= {{W{1'b0}}, mag_b_s};
          end
          state_r <= S_CALC;
        end
        S_CALC: begin
          acc_r <= op_r[2] ? div_next_s : mul_next_s;
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == CW'(W - 1)) begin
            state_r <= S_FIX;
          end else begin
            state_r <= S_CALC;
          end
        end
        S_FIX: begin
          result  <= fix_s;
          busy    <= 1'b0;
          done    <= 1'b1;
          state_r <= S_DONE;
        end
        default: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
